// File: rtl/systemspec_host.sv
// Initiator sequencer: queues (a,b,x) commands, issues each to systemspec with a one-cycle start, returns z or a timeout error.
// Latency: issue edge to res_valid is 2 cycles plus the systemspec compute time; a queued command issues one cycle after RESULT exits.
// Backpressure: cmd_ready drops while the FIFO holds DEPTH entries; a result is held stable in RESULT until res_ready is seen.
//
// Ports:
//   clk, rst                       clock and asynchronous active-high reset
//   cmd_valid/cmd_ready            upstream command handshake; cmd_a, cmd_b, cmd_x are the command fields
//   start, a, b, x                 registered issue pulse and operands to systemspec (operands held until the next issue)
//   ready, z                       systemspec idle/done flag and result
//   res_valid/res_ready            upstream result handshake; res_z, res_err are the result fields
//   busy                           FSM not idle, or commands still queued

// Generic synchronous FIFO with first-word fall-through read data.
// Latency: a pushed word is visible on rd_dat the cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored.
module systemspec_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign push   = wr_vld & ~full;
  assign pop    = rd_rdy & ~empty;
  assign rd_dat = mem[rd_ptr];

  // Pointers are AW bits wide and DEPTH is a power of two, so they wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: it is only read once count says the slot is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end

endmodule

module systemspec_host #(
  parameter int DEPTH = 4,
  parameter int TMO   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_a,
  input  logic       cmd_b,
  input  logic [3:0] cmd_x,
  output logic       start,
  output logic       a,
  output logic       b,
  output logic [3:0] x,
  input  logic       ready,
  input  logic [3:0] z,
  output logic       res_valid,
  output logic [3:0] res_z,
  output logic       res_err,
  input  logic       res_ready,
  output logic       busy
);

  localparam int CNTW = $clog2(TMO + 1);

  typedef struct packed {
    logic       a;
    logic       b;
    logic [3:0] x;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_LO = 2'd1,
    WAIT_HI = 2'd2,
    RESULT  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CNTW-1:0] cnt;
  logic            cnt_last;

  cmd_t            fifo_wr_dat;
  cmd_t            fifo_rd_dat;
  logic            fifo_full;
  logic            fifo_empty;

  logic            issue;
  logic            done_ok;
  logic            done_err;
  logic            res_take;
  logic            cnt_clr;
  logic            cnt_inc;

  // ------------------------------------------------------------------
  // Command queue
  // ------------------------------------------------------------------
  assign fifo_wr_dat = '{a: cmd_a, b: cmd_b, x: cmd_x};
  // cmd_ready follows the pre-edge count, so a pop on a full FIFO does not
  // admit a push in the same cycle.
  assign cmd_ready   = ~fifo_full;

  systemspec_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(cmd_t))
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (cmd_valid),
    .wr_dat (fifo_wr_dat),
    .rd_rdy (issue),
    .rd_dat (fifo_rd_dat),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Counter reaches TMO on the edge where it would step past TMO-1.
  assign cnt_last = (cnt == CNTW'(TMO - 1));

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ------------------------------------------------------------------
  // FSM: next state
  // ------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty && ready) state_nxt = WAIT_LO;
      WAIT_LO: begin
        if (!ready)        state_nxt = WAIT_HI;
        else if (cnt_last) state_nxt = RESULT;
      end
      WAIT_HI: begin
        if (ready)         state_nxt = RESULT;
        else if (cnt_last) state_nxt = RESULT;
      end
      RESULT:  if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // FSM: control decode
  // ------------------------------------------------------------------
  always_comb begin
    issue    = 1'b0;
    done_ok  = 1'b0;
    done_err = 1'b0;
    res_take = 1'b0;
    cnt_inc  = 1'b0;
    case (state)
      IDLE:    issue = !fifo_empty && ready;
      WAIT_LO: begin
        cnt_inc  = 1'b1;
        done_err = ready && cnt_last;
      end
      WAIT_HI: begin
        cnt_inc  = 1'b1;
        done_ok  = ready;
        done_err = !ready && cnt_last;
      end
      RESULT:  res_take = res_ready;
      default: ;
    endcase
    // Every state change restarts the wait budget.
    cnt_clr = (state_nxt != state);
  end

  assign busy = (state != IDLE) || !fifo_empty;

  // ------------------------------------------------------------------
  // Registered outputs and timeout counter
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start     <= 1'b0;
      a         <= 1'b0;
      b         <= 1'b0;
      x         <= '0;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_z     <= '0;
      res_err   <= 1'b0;
    end else begin
      start <= issue;
      // Operands only move on issue, so they stay frozen through the wait and result states.
      if (issue) begin
        a <= fifo_rd_dat.a;
        b <= fifo_rd_dat.b;
        x <= fifo_rd_dat.x;
      end

      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;

      if (done_ok) begin
        res_valid <= 1'b1;
        res_z     <= z;
        res_err   <= 1'b0;
      end else if (done_err) begin
        res_valid <= 1'b1;
        res_z     <= '0;
        res_err   <= 1'b1;
      end else if (res_take) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule
